// File: rtl/pong_match_ctrl.sv
// pong_match_ctrl: paddle positions, ball motion, collision, scoring and
// serve/rally/point/game-over sequencing for the pong core.
// Everything advances only on clk edges where tick=1.
// Optional feature macro: PONG_SPIN_EN -- when defined, a paddle's up/down
// request on the hitting tick steers the ball's vertical direction.
//
// state | meaning
// IDLE  | after reset, ball centred, waiting for start
// SERVE | ball held at centre while the serve counter runs down
// RALLY | ball in play, walls and paddles reflect it
// POINT | one tick to award the point and pick the next state
// OVER  | match finished, ball/scores/paddles frozen until start
module pong_match_ctrl #(
  parameter int FIELD_W     = 64,
  parameter int FIELD_H     = 32,
  parameter int PAD_H       = 6,
  parameter int SCORE_W     = 4,
  parameter int WIN_SCORE   = 9,
  parameter int SERVE_DELAY = 16,
  localparam int XW = $clog2(FIELD_W),
  localparam int YW = $clog2(FIELD_H)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic               start,
  input  logic               pvp,
  input  logic               l_up,
  input  logic               l_dn,
  input  logic               r_up,
  input  logic               r_dn,
  output logic [YW-1:0]      left_pad_y,
  output logic [YW-1:0]      right_pad_y,
  output logic [XW-1:0]      ball_x,
  output logic [YW-1:0]      ball_y,
  output logic [SCORE_W-1:0] left_score,
  output logic [SCORE_W-1:0] right_score,
  output logic [2:0]         state,
  output logic               point,
  output logic               winner
);

  localparam int CW = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;

  localparam logic [XW-1:0]      X_CTR    = XW'(FIELD_W / 2);
  localparam logic [XW-1:0]      X_LCHK   = XW'(1);
  localparam logic [XW-1:0]      X_LBACK  = XW'(2);
  localparam logic [XW-1:0]      X_RCHK   = XW'(FIELD_W - 2);
  localparam logic [XW-1:0]      X_RBACK  = XW'(FIELD_W - 3);
  localparam logic [XW-1:0]      X_RGOAL  = XW'(FIELD_W - 1);
  localparam logic [YW-1:0]      Y_CTR    = YW'(FIELD_H / 2);
  localparam logic [YW-1:0]      Y_BOT    = YW'(FIELD_H - 1);
  localparam logic [YW-1:0]      Y_BOT1   = YW'(FIELD_H - 2);
  localparam logic [YW-1:0]      PAD_MAX  = YW'(FIELD_H - PAD_H);
  localparam logic [YW-1:0]      PAD_RST  = YW'((FIELD_H - PAD_H) / 2);
  localparam logic [YW-1:0]      PAD_LEN  = YW'(PAD_H);
  localparam logic [SCORE_W-1:0] WIN      = SCORE_W'(WIN_SCORE);
  localparam logic [CW-1:0]      CNT_LOAD = CW'(SERVE_DELAY - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_RALLY = 3'd2,
    S_POINT = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [YW-1:0]      lpad_q, lpad_d, rpad_q, rpad_d;
  logic [XW-1:0]      bx_q, bx_d;
  logic [YW-1:0]      by_q, by_d;
  logic               dx_q, dx_d;        // 1 = moving right
  logic               dy_q, dy_d;        // 1 = moving down
  logic [SCORE_W-1:0] lscore_q, lscore_d, rscore_q, rscore_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               pvp_q, pvp_d;
  logic               scorer_q, scorer_d; // 1 = right player scored
  logic               winner_q, winner_d;
  logic               point_q, point_d;
  logic [SCORE_W-1:0] pt_score;
  logic               l_hit, r_hit;

  function automatic logic [YW-1:0] pad_next(input logic [YW-1:0] p,
                                             input logic up, input logic dn);
    if (up && !dn && p != '0) return p - 1'b1;
    if (dn && !up && p < PAD_MAX) return p + 1'b1;
    return p;
  endfunction

  // Hit tests read the paddle position registered before this tick.
  assign l_hit = (by_q >= lpad_q) && ((by_q - lpad_q) < PAD_LEN);
  assign r_hit = (by_q >= rpad_q) && ((by_q - rpad_q) < PAD_LEN);

  // State register and all game registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      lpad_q   <= PAD_RST;
      rpad_q   <= PAD_RST;
      bx_q     <= X_CTR;
      by_q     <= Y_CTR;
      dx_q     <= 1'b1;
      dy_q     <= 1'b1;
      lscore_q <= '0;
      rscore_q <= '0;
      cnt_q    <= '0;
      pvp_q    <= 1'b0;
      scorer_q <= 1'b0;
      winner_q <= 1'b0;
      point_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      lpad_q   <= lpad_d;
      rpad_q   <= rpad_d;
      bx_q     <= bx_d;
      by_q     <= by_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      lscore_q <= lscore_d;
      rscore_q <= rscore_d;
      cnt_q    <= cnt_d;
      pvp_q    <= pvp_d;
      scorer_q <= scorer_d;
      winner_q <= winner_d;
      point_q  <= point_d;
    end
  end

  // Next-state logic: match sequencing, ball motion, collisions, scoring, paddles.
  always_comb begin
    state_d  = state_q;
    lpad_d   = lpad_q;
    rpad_d   = rpad_q;
    bx_d     = bx_q;
    by_d     = by_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    lscore_d = lscore_q;
    rscore_d = rscore_q;
    cnt_d    = cnt_q;
    pvp_d    = pvp_q;
    scorer_d = scorer_q;
    winner_d = winner_q;
    point_d  = 1'b0;                      // pulse lasts one clk regardless of tick
    pt_score = (scorer_q ? rscore_q : lscore_q) + 1'b1;

    if (tick) begin
      if (state_q != S_OVER) begin
        lpad_d = pad_next(lpad_q, l_up, l_dn);
        rpad_d = pad_next(rpad_q, r_up, r_dn);
      end

      case (state_q)
        S_IDLE, S_OVER: begin
          if (start) begin
            state_d  = S_SERVE;
            lscore_d = '0;
            rscore_d = '0;
            pvp_d    = pvp;
            dx_d     = 1'b1;
            cnt_d    = CNT_LOAD;
            bx_d     = X_CTR;
            by_d     = Y_CTR;
            winner_d = 1'b0;
          end
        end

        S_SERVE: begin
          bx_d = X_CTR;
          by_d = Y_CTR;
          if (cnt_q == '0) begin
            state_d = S_RALLY;
            dy_d    = 1'b1;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end

        S_RALLY: begin
          // vertical motion with wall reflection
          if (!dy_q && by_q == '0) begin
            dy_d = 1'b1;
            by_d = YW'(1);
          end else if (dy_q && by_q == Y_BOT) begin
            dy_d = 1'b0;
            by_d = Y_BOT1;
          end else begin
            by_d = dy_q ? by_q + 1'b1 : by_q - 1'b1;
          end

          // horizontal motion with paddle checks; corner cases keep the wall result
          if (!dx_q && bx_q == X_LCHK) begin
            if (l_hit) begin
              dx_d = 1'b1;
              bx_d = X_LBACK;
              if (!pvp_q && lscore_q < WIN) lscore_d = lscore_q + 1'b1;
`ifdef PONG_SPIN_EN
              if (l_up && !l_dn) dy_d = 1'b0;
              else if (l_dn && !l_up) dy_d = 1'b1;
`endif
            end else begin
              bx_d     = '0;
              state_d  = S_POINT;
              scorer_d = 1'b1;
              point_d  = 1'b1;
            end
          end else if (dx_q && bx_q == X_RCHK) begin
            if (r_hit) begin
              dx_d = 1'b0;
              bx_d = X_RBACK;
              if (!pvp_q && rscore_q < WIN) rscore_d = rscore_q + 1'b1;
`ifdef PONG_SPIN_EN
              if (r_up && !r_dn) dy_d = 1'b0;
              else if (r_dn && !r_up) dy_d = 1'b1;
`endif
            end else begin
              bx_d     = X_RGOAL;
              state_d  = S_POINT;
              scorer_d = 1'b0;
              point_d  = 1'b1;
            end
          end else begin
            bx_d = dx_q ? bx_q + 1'b1 : bx_q - 1'b1;
          end
        end

        S_POINT: begin
          if (pvp_q) begin
            if (scorer_q) rscore_d = pt_score;
            else          lscore_d = pt_score;
            dx_d = ~scorer_q;                 // serve toward the conceding player
            if (pt_score == WIN) begin
              state_d  = S_OVER;
              winner_d = scorer_q;
            end else begin
              state_d = S_SERVE;
              cnt_d   = CNT_LOAD;
              bx_d    = X_CTR;
              by_d    = Y_CTR;
            end
          end else begin
            state_d  = S_OVER;
            winner_d = 1'b0;
          end
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  assign left_pad_y  = lpad_q;
  assign right_pad_y = rpad_q;
  assign ball_x      = bx_q;
  assign ball_y      = by_q;
  assign left_score  = lscore_q;
  assign right_score = rscore_q;
  assign state       = state_q;
  assign point       = point_q;
  assign winner      = winner_q;

endmodule

// File: doc/pong_match_ctrl.md
# pong_match_ctrl

Parametrised match controller for the pong core. It owns both paddle positions, the ball position and direction, collision and wall reflection, scoring, and a serve/rally/point/game-over state machine. It runs at a game-rate `tick` enable derived from `clk`. It sits between the debounced player inputs and the VGA renderer, and replaces the fixed 64x32 game block with a generic field size, paddle height and win condition.

## Interface
Parameters:
- FIELD_W, 64, field width in cells; ≥ 8
- FIELD_H, 32, field height in cells; ≥ PAD_H+2
- PAD_H, 6, paddle height in cells
- SCORE_W, 4, score counter width
- WIN_SCORE, 9, score that ends the match; < 2^SCORE_W
- SERVE_DELAY, 16, ticks the ball rests at centre before a serve

Ports (XW = $clog2(FIELD_W), YW = $clog2(FIELD_H)):
- clk  in  1  clock
- reset  in  1  asynchronous, active-low
- tick  in  1  game-rate enable; all game state advances only on clk edges with tick=1
- start  in  1  level; leaves IDLE/OVER on a tick edge
- pvp  in  1  1 = player vs player, 0 = co-op rally; sampled only when leaving IDLE/OVER
- l_up, l_dn, r_up, r_dn  in  1 each  paddle move requests
- left_pad_y, right_pad_y  out  YW  paddle top row
- ball_x  out  XW
- ball_y  out  YW
- left_score, right_score  out  SCORE_W
- state  out  3  IDLE=0, SERVE=1, RALLY=2, POINT=3, OVER=4
- point  out  1  one-clk pulse when a point is awarded or a co-op rally ends
- winner  out  1  valid in OVER; 0 = left, 1 = right (co-op: 0)

## Operation
- Paddles move in all states except OVER, one row per tick.
  - up decrements, down increments; both asserted = hold.
  - Saturate at 0 and FIELD_H-PAD_H.
- Ball occupies columns 0..FIELD_W-1. The left paddle face is column 0; the right paddle face is column FIELD_W-1.
- IDLE:
  - Ball centred at (FIELD_W/2, FIELD_H/2).
  - On start → SERVE; clear scores; latch pvp; serve direction dx=right.
- SERVE:
  - Ball held at centre; counter loads SERVE_DELAY-1 on entry and decrements per tick.
  - At 0 → RALLY; dy=down.
- RALLY, each tick:
  - y moves by dy.
  - At row 0 moving up, or row FIELD_H-1 moving down: dy flips and y moves one row the new way.
- Left check (x==1, dx=left):
  - Hit when left_pad_y ≤ ball_y ≤ left_pad_y+PAD_H-1. Then dx flips, x←2; co-op adds +1 to left_score.
  - Otherwise → POINT; scorer is right.
- Right check (x==FIELD_W-2, dx=right): mirror of the left check.
- Otherwise x moves by dx.
- POINT (one tick):
  - pvp: scorer +1; next serve goes toward the conceding player.
  - Co-op: no score change; → OVER.
  - pvp and updated score == WIN_SCORE → OVER with winner = scorer; else → SERVE.
- Co-op hit making score == WIN_SCORE: score saturates at WIN_SCORE and the rally continues.
- OVER:
  - Ball and scores frozen.
  - start → SERVE with cleared scores (same as IDLE exit).
- Reset mid-game → all outputs to reset values immediately (asynchronous).

## Timing
- Reset values:
  - Paddles at (FIELD_H-PAD_H)/2.
  - Ball at centre.
  - Scores 0; state IDLE.
  - point 0; winner 0; dx right; dy down.
- All outputs are registered. Any state or position change is visible on the clk edge following the tick edge that caused it, i.e. one clk latency.
- point asserts for exactly one clk, on the edge that enters POINT.
- tick=0 freezes everything, including the serve counter and paddles.
- Collision uses the paddle position registered before the current tick; a paddle moving on the same tick does not affect that hit test.
- Wall bounce and paddle hit on the same tick (corner) are both applied.

## Configuration
- PONG_SPIN_EN defined: on a paddle hit, if that paddle's up (down) request is asserted on the hitting tick, dy is forced up (down). If neither request is asserted, dy is unchanged.
- Undefined: paddle input never alters dy.

## Test plan
- Reset, start=1 one tick, SERVE_DELAY=16 → state SERVE for 16 ticks, then RALLY with ball leaving (32,16) toward x=33.
- Left paddle at rows 10..15, ball reaches x=1 at y=12 moving left → dx right, x=2 next tick; pvp scores unchanged; co-op left_score 0→1.
- Ball reaches x=1 at y=20 with left paddle at rows 10..15, pvp → point pulse; right_score +1; next serve heads left.
- right_score=8 and left misses, pvp → right_score=9, state OVER, winner=1; start → scores 0, state SERVE.
- l_up held 40 ticks from reset → left_pad_y saturates at 0; l_up and l_dn both asserted → position held.
- PONG_SPIN_EN defined, hit at right paddle with r_up asserted while dy=down → dy up on the next tick. Without the macro, dy stays down.
